// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, centre-of-bit sampling, and a
// one-entry holding register with a valid/ready output handshake.
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_FREQ_HZ = 125_000_000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_i,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic [1:0]            dbg_state
);

    localparam int CPB   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CPB - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    if (CPB < 4) begin : g_bad_cpb
        $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic                  rx_prev;
    logic [CNT_W-1:0]      bit_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_q;

    assign dbg_state = state;

    // Handshake: a byte moves downstream on every cycle where valid_o and ready_i
    // are both high; data_o is frozen while valid_o is high and not yet taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift_q     <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            rx_meta     <= rx_i;
            rx_s        <= rx_meta;
            rx_prev     <= rx_s;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;

            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == CPB_LAST) begin
                        bit_cnt <= '0;
                        shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_cnt == CPB_LAST) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                        if (!rx_s) begin
                            frame_err_o <= 1'b1;
                        end else if (!valid_o || ready_i) begin
                            // Covers the simultaneous take-and-refill case too.
                            data_o  <= shift_q;
                            valid_o <= 1'b1;
                        end else begin
                            overrun_o <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
